// File: rtl/multi_channel_pulse_generator.sv
// multi_channel_pulse_generator: N_CH PPS-aligned pulse trains armed by a Thunderbolt time match.
// Define PULSE_GEN_PPS_RESYNC_EN to realign all channels to every PPS edge while running.
module multi_channel_pulse_generator #(
  parameter int CLKS_PER_1_US = 100,
  parameter int N_CH = 4,
  parameter int CNT_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH-1:0]       i_pulse_enable,
  input  logic                  i_pps_raw,
  input  logic [15:0]           i_usr_year,
  input  logic [7:0]            i_usr_month,
  input  logic [7:0]            i_usr_day,
  input  logic [7:0]            i_usr_hour,
  input  logic [7:0]            i_usr_minutes,
  input  logic [7:0]            i_usr_seconds,
  input  logic [N_CH*CNT_W-1:0] i_width_high,
  input  logic [N_CH*CNT_W-1:0] i_width_period,
  input  logic [N_CH*CNT_W-1:0] i_phase_us,
  input  logic                  i_thunder_packet_dv,
  input  logic [15:0]           i_thunder_year,
  input  logic [7:0]            i_thunder_month,
  input  logic [7:0]            i_thunder_day,
  input  logic [7:0]            i_thunder_hour,
  input  logic [7:0]            i_thunder_minutes,
  input  logic [7:0]            i_thunder_seconds,
  output logic [N_CH-1:0]       o_pulse_out,
  output logic                  o_armed,
  output logic                  o_running
);
  localparam int PW = $clog2(CLKS_PER_1_US);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED, S_RUN} state_t;
  state_t r_state, w_next;
  logic [3:0] r_pps_sh;
  logic r_pps_edge, r_armed, r_running;
  logic [PW-1:0] r_presc;
  logic [N_CH-1:0] r_pulse, w_pulse_nx;
  logic w_en_any, w_match, w_start, w_restart, w_live, w_tick;
  assign w_en_any = |i_pulse_enable;
  assign w_match = i_thunder_packet_dv && i_thunder_year == i_usr_year && i_thunder_month == i_usr_month &&
                   i_thunder_day == i_usr_day && i_thunder_hour == i_usr_hour &&
                   i_thunder_minutes == i_usr_minutes && i_thunder_seconds == i_usr_seconds;
  assign w_start = r_state == S_ARMED && r_pps_edge && w_en_any;
`ifdef PULSE_GEN_PPS_RESYNC_EN
  assign w_restart = w_start || (r_state == S_RUN && r_pps_edge);
`else
  assign w_restart = w_start;
`endif
  assign w_live = w_start || (r_state == S_RUN && w_en_any);
  assign w_tick = r_state == S_RUN && r_presc == PW'(CLKS_PER_1_US - 1);
  // two sync flops, one delay flop, then a registered rising-edge strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pps_sh <= '0;
      r_pps_edge <= 1'b0;
    end else begin
      r_pps_sh <= {r_pps_sh[2:0], i_pps_raw};
      r_pps_edge <= r_pps_sh[2] & ~r_pps_sh[3];
    end
  end
  always_comb begin
    w_next = !w_en_any ? S_IDLE :
             r_state == S_IDLE ? S_WAIT :
             (r_state == S_WAIT && w_match) ? S_ARMED :
             (r_state == S_ARMED && r_pps_edge) ? S_RUN : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_running <= 1'b0;
      r_presc <= '0;
      r_pulse <= '0;
    end else begin
      r_state <= w_next;
      r_armed <= w_next == S_ARMED;
      r_running <= w_next == S_RUN;
      r_presc <= (!w_live || w_restart || w_tick) ? '0 : r_presc + 1'b1;
      r_pulse <= w_live ? w_pulse_nx : '0;
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] r_w, r_p, r_ph, r_ph_cnt, r_cnt;
    logic [CNT_W-1:0] w_w, w_p, w_ph, w_ph_nx, w_cnt_nx;
    assign w_w = w_start ? i_width_high[k*CNT_W +: CNT_W] : r_w;
    assign w_p = w_start ? i_width_period[k*CNT_W +: CNT_W] : r_p;
    assign w_ph = w_start ? i_phase_us[k*CNT_W +: CNT_W] : r_ph;
    assign w_ph_nx = w_restart ? '0 : (w_tick && r_ph_cnt != r_ph) ? r_ph_cnt + 1'b1 : r_ph_cnt;
    assign w_cnt_nx = w_restart ? '0 :
                      (w_tick && r_ph_cnt == r_ph) ? ((r_cnt == r_p - 1'b1) ? '0 : r_cnt + 1'b1) : r_cnt;
    // evaluated on next-state counters so the output register lines up with them
    assign w_pulse_nx[k] = i_pulse_enable[k] && w_p != '0 && w_ph_nx == w_ph && w_cnt_nx < w_w;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_w <= '0;
        r_p <= '0;
        r_ph <= '0;
      end else if (w_start) begin
        r_w <= w_w;
        r_p <= w_p;
        r_ph <= w_ph;
      end
    end
    always_ff @(posedge i_clk) begin
      if (i_rst || !w_live) begin
        r_ph_cnt <= '0;
        r_cnt <= '0;
      end else begin
        r_ph_cnt <= w_ph_nx;
        r_cnt <= w_cnt_nx;
      end
    end
  end
  assign o_pulse_out = r_pulse;
  assign o_armed = r_armed;
  assign o_running = r_running;
endmodule

// File: doc/multi_channel_pulse_generator.md
# multi_channel_pulse_generator

Parametrised successor to the single-output pulse generator. Drives `N_CH` independent, PPS-aligned pulse trains, each with its own enable, high width, period and phase offset in microseconds. All channels share one user start time. Pulsing is armed when a Thunderbolt timing packet matches the start time, and begins on the next PPS edge. The block sits between the Thunderbolt packet decoder/PPS input and the board trigger outputs.

## Interface
- `CLKS_PER_1_US`, 100: i_clk cycles per microsecond; must be ≥2.
- `N_CH`, 4: number of output channels, 1..16.
- `CNT_W`, 32: width of per-channel width/period/phase fields and counters.

Ports:
- `i_clk`  in  1  system clock; the only clock.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_pulse_enable`  in  N_CH  per-channel enable.
- `i_pps_raw`  in  1  asynchronous raw PPS.
- `i_usr_year`/`i_usr_month`/`i_usr_day`/`i_usr_hour`/`i_usr_minutes`/`i_usr_seconds`  in  16/8/8/8/8/8  shared start time.
- `i_width_high`  in  N_CH*CNT_W  per-channel high time, µs; channel k occupies bits [k*CNT_W +: CNT_W].
- `i_width_period`  in  N_CH*CNT_W  per-channel period, µs.
- `i_phase_us`  in  N_CH*CNT_W  per-channel delay from the start PPS to the first rising edge, µs.
- `i_thunder_packet_dv`  in  1  one-cycle packet valid.
- `i_thunder_year`..`i_thunder_seconds`  in  16/8/8/8/8/8  packet time.
- `o_pulse_out`  out  N_CH  registered pulse outputs.
- `o_armed`  out  1  high while in ARMED.
- `o_running`  out  1  high while in RUN.

## Operation
- PPS path: 2-flop synchroniser, then a rising-edge detector producing a one-cycle `pps_edge`.
- FSM states:
  - IDLE → WAIT_MATCH when `|i_pulse_enable`.
  - WAIT_MATCH → ARMED on a `i_thunder_packet_dv` cycle where all six thunder fields equal the user fields.
  - ARMED → RUN on `pps_edge`.
  - RUN holds until a stop condition.
- Stop condition: from any state, `i_pulse_enable == 0` returns the FSM to IDLE on the next cycle and forces all outputs low.
- On the ARMED→RUN edge:
  - latch `i_width_high`, `i_width_period` and `i_phase_us` for every channel; mid-run input changes are ignored until the next arm;
  - clear the µs prescaler;
  - clear all channel counters.
- µs tick: the prescaler counts 0..CLKS_PER_1_US-1 and emits a tick on wrap.
- Per channel k, in RUN:
  - phase counter counts ticks up to phase_k;
  - the channel's period counter then runs 0..period_k-1 and wraps;
  - `o_pulse_out[k] = en_k && period_k != 0 && cnt_k < width_k`.
- Arithmetic and width rules:
  - width = 0 → output stays low;
  - width ≥ period → output constant high after the phase delay;
  - period = 0 → channel disabled;
  - counters are CNT_W wide and compare unsigned.
- Per-channel enable deassertion in RUN: output goes low on the next cycle; that channel's counters keep running so re-enable stays phase-coherent.
- Simultaneous events:
  - a dv match and `pps_edge` in the same WAIT_MATCH cycle → ARMED only; RUN starts on the following PPS;
  - a non-matching dv in ARMED is ignored.
- Reset values: `o_pulse_out=0`, `o_armed=0`, `o_running=0`, FSM=IDLE, all counters 0. Reset asserted mid-operation has the same effect on the next clock edge.

## Timing
- `pps_edge` asserts 3 clocks after the first clock edge that samples `i_pps_raw` high.
- `o_running` rises 1 clock after `pps_edge`.
- A channel with phase 0 and width>0 drives `o_pulse_out` high in that same cycle.
- High time: exactly width×CLKS_PER_1_US clocks.
- Period: exactly period×CLKS_PER_1_US clocks.
- Phase delay: adds phase×CLKS_PER_1_US clocks.
- `o_armed` rises 1 clock after the matching dv cycle.
- All outputs are registered; no combinational paths from inputs to outputs.

## Configuration
- `PULSE_GEN_PPS_RESYNC_EN` defined:
  - in RUN, every `pps_edge` clears the prescaler and all phase/period counters, restarting each channel's phase delay;
  - outputs are therefore realigned to PPS every second, and accumulated clock drift is discarded.
- Undefined: after the start PPS, channels free-run on i_clk; later PPS edges have no effect.

## Test plan
(CLKS_PER_1_US=10, N_CH=4, 100 ns clock, PPS every 100 µs of simulated time)
- Arm/start: user time 2020-07-15 11:55:30; packets carry seconds 28, 29, 30, each 1 cycle after a PPS → `o_armed` 1 clk after the seconds=30 packet; ch0 (w=2, p=8, ph=0) rises 3+1 clk after the next PPS, high 20 clk, period 80 clk.
- Phase/multi-channel: ch1 w=3 p=8 ph=5 → first rise 50 clk after ch0's first rise; ch2 w=0 → always low; ch3 w=10 p=8 → constant high.
- Mismatch/simultaneity: seconds=29 packet only → never armed; matching dv in the same cycle as a PPS edge → RUN starts one PPS later.
- Enable control: drop bit 1 for 37 clk mid-run → low next cycle, and phase preserved on return; drop all bits → IDLE, outputs 0, and re-arm required.
- Reset mid-RUN: assert `i_rst` for 1 clk → all outputs 0, state IDLE on the next edge.
- Resync: period 7 µs with 100 µs PPS → with `PULSE_GEN_PPS_RESYNC_EN` the counters restart at each PPS; without it the train continues unbroken.
